dmem_ctrl: RTL

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/dmem_ctrl.sv
// Data-memory stage controller: turns EX/MEM loads/stores into a req/ack memory
// transaction, stalls the pipeline while waiting, and loads the MEM/WB register.
module dmem_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_busC,
  input  logic [31:0] i_busB,
  input  logic [4:0]  i_rd,
  input  logic        i_GPRWR,
  input  logic        i_DMWR,
  input  logic        i_MTR,
  output logic        o_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] o_busW,
  output logic [4:0]  o_rd,
  output logic        o_GPRWR,
  output logic        o_err
);

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;
  logic        mem_we_q, mem_we_d;
  logic [29:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] busw_q, busw_d;
  logic [4:0]  rd_q, rd_d;
  logic        gprwr_q, gprwr_d;
  logic        err_q, err_d;

  logic memop, aligned, is_load, in_access;
  logic misaligned, tmo_hit, load_done, stall;

  assign memop      = i_DMWR | i_MTR;
  assign aligned    = (i_busC[1:0] == 2'b00);
  // Both controls set is treated as a store.
  assign is_load    = i_MTR & ~i_DMWR;
  assign in_access  = (state_q == StAccess);
  assign misaligned = ~in_access & memop & ~aligned;
  assign tmo_hit    = in_access & ~mem_ack & (tmo_cnt_q == TmoLast);
  assign load_done  = in_access & mem_ack & is_load;

  always_comb begin
    state_d     = state_q;
    tmo_cnt_d   = tmo_cnt_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    stall       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (memop && aligned) begin
          stall       = 1'b1;
          state_d     = StAccess;
          tmo_cnt_d   = 8'd0;
          mem_we_d    = i_DMWR;
          mem_addr_d  = i_busC[31:2];
          mem_wdata_d = i_busB;
        end
      end
      StAccess: begin
        if (mem_ack || tmo_hit) begin
          state_d = StIdle;
        end else begin
          stall     = 1'b1;
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // MEM/WB register: advance when not stalled, otherwise insert a bubble.
  always_comb begin
    busw_d  = busw_q;
    rd_d    = rd_q;
    gprwr_d = 1'b0;
    err_d   = misaligned | tmo_hit;
    if (!stall) begin
      rd_d    = i_rd;
      busw_d  = load_done ? mem_rdata : i_busC;
      gprwr_d = i_GPRWR & ~misaligned & ~(tmo_hit & is_load);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      tmo_cnt_q   <= 8'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 30'd0;
      mem_wdata_q <= 32'd0;
      busw_q      <= 32'd0;
      rd_q        <= 5'd0;
      gprwr_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_cnt_q   <= tmo_cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busw_q      <= busw_d;
      rd_q        <= rd_d;
      gprwr_q     <= gprwr_d;
      err_q       <= err_d;
    end
  end

  assign o_stall   = stall;
  assign mem_req   = in_access;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign o_busW    = busw_q;
  assign o_rd      = rd_q;
  assign o_GPRWR   = gprwr_q;
  assign o_err     = err_q;

endmodule
